// File: rtl/rx_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_uart_pkg
// Brief    : Shared UART constants and one-hot state encoding for the debug
//            link receiver (also used by the link transmitter).
// Revision : 1.0 - initial release
// ============================================================================
package rx_uart_pkg;

    localparam int NB_STATE    = 4;
    localparam int N_DATA      = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int DATA_TICKS  = OVERSAMPLE - 1;
    localparam int START_TICKS = (OVERSAMPLE / 2) - 1;
    localparam int TICK_CNT_W  = 4;

    localparam logic START_VALUE = 1'b0;
    localparam logic STOP_VALUE  = 1'b1;

    // One-hot receiver states; the encoding is visible on the debug port
    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } state_e;

endpackage : rx_uart_pkg
`default_nettype wire

// File: rtl/rx_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_uart_if
// Brief    : Serial input / parallel output bundle of the UART receiver.
//            master = line/tick source and byte consumer, slave = receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface rx_uart_if #(
    parameter int DW = 8,
    parameter int SW = 4
);
    logic          rx;
    logic          s_tick;
    logic [DW-1:0] dout;
    logic          rx_done_tick;
    logic          frame_err;
    logic [SW-1:0] state;

    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  frame_err,
        input  state
    );

    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output frame_err,
        output state
    );
endinterface : rx_uart_if
`default_nettype wire

// File: rtl/rx_uart_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for one asynchronous bit with a
//            configurable reset level.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  wire  clock,
    input  wire  reset,
    input  wire  i_d,
    output logic o_q
);
    logic r_meta_q;
    logic r_sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta_q <= RESET_VALUE;
            r_sync_q <= RESET_VALUE;
        end else begin
            r_meta_q <= i_d;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_q = r_sync_q;
endmodule : sync_2ff
`default_nettype wire

// File: rtl/rx_uart.sv
`default_nettype none
// ============================================================================
// Module   : rx_uart
// Brief    : 16x oversampled UART receiver. 1 start, N_DATA data bits LSB
//            first, 1 stop, no parity. Emits a one-clock rx_done_tick with
//            the byte on dout, or a one-clock frame_err on a bad stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module rx_uart #(
    parameter int N_DATA      = rx_uart_pkg::N_DATA,
    parameter int DATA_TICKS  = rx_uart_pkg::DATA_TICKS,
    parameter int START_TICKS = rx_uart_pkg::START_TICKS
) (
    input  wire   clock,
    input  wire   reset,
    rx_uart_if.slave bus
);
    import rx_uart_pkg::*;

    localparam int                  BIT_CNT_W     = (N_DATA > 1) ? $clog2(N_DATA) : 1;
    localparam logic [TICK_CNT_W-1:0] c_DATA_TICKS  = TICK_CNT_W'(DATA_TICKS);
    localparam logic [TICK_CNT_W-1:0] c_START_TICKS = TICK_CNT_W'(START_TICKS);
    localparam logic [BIT_CNT_W-1:0]  c_LAST_BIT    = BIT_CNT_W'(N_DATA - 1);

    logic w_rx_s;

    state_e                r_state_q,    w_state_d;
    logic [TICK_CNT_W-1:0] r_tick_cnt_q, w_tick_cnt_d;
    logic [BIT_CNT_W-1:0]  r_bit_cnt_q,  w_bit_cnt_d;
    logic [N_DATA-1:0]     r_shift_q,    w_shift_d;
    logic [N_DATA-1:0]     r_dout_q,     w_dout_d;
    logic                  r_done_q,     w_done_d;
    logic                  r_ferr_q,     w_ferr_d;
    logic                  r_armed_q,    w_armed_d;

    sync_2ff #(
        .RESET_VALUE (STOP_VALUE)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (bus.rx),
        .o_q   (w_rx_s)
    );

    // Next-state / datapath: everything except the start edge waits for s_tick
    always_comb begin
        w_state_d    = r_state_q;
        w_tick_cnt_d = r_tick_cnt_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_shift_d    = r_shift_q;
        w_dout_d     = r_dout_q;
        w_done_d     = 1'b0;
        w_ferr_d     = 1'b0;
        w_armed_d    = r_armed_q;

        case (r_state_q)
            ST_IDLE: begin
                // Arming on an idle level stops a held-low line from
                // retriggering after a framing error.
                if (w_rx_s == STOP_VALUE) begin
                    w_armed_d = 1'b1;
                end
                if (r_armed_q && (w_rx_s == START_VALUE)) begin
                    w_state_d    = ST_START;
                    w_tick_cnt_d = '0;
                    w_armed_d    = 1'b0;
                end
            end

            ST_START: begin
                if (bus.s_tick) begin
                    if (r_tick_cnt_q == c_START_TICKS) begin
                        if (w_rx_s == START_VALUE) begin
                            w_state_d    = ST_DATA;
                            w_tick_cnt_d = '0;
                            w_bit_cnt_d  = '0;
                        end else begin
                            // Too short to be a start bit: drop it silently
                            w_state_d = ST_IDLE;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (bus.s_tick) begin
                    if (r_tick_cnt_q == c_DATA_TICKS) begin
                        w_shift_d    = {w_rx_s, r_shift_q[N_DATA-1:1]};
                        w_tick_cnt_d = '0;
                        if (r_bit_cnt_q == c_LAST_BIT) begin
                            w_state_d = ST_STOP;
                        end else begin
                            w_bit_cnt_d = r_bit_cnt_q + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (bus.s_tick) begin
                    if (r_tick_cnt_q == c_DATA_TICKS) begin
                        w_state_d    = ST_IDLE;
                        w_tick_cnt_d = '0;
                        if (w_rx_s == STOP_VALUE) begin
                            w_dout_d  = r_shift_q;
                            w_done_d  = 1'b1;
                            // Line already idle mid-stop: accept a start
                            // edge right after leaving STOP
                            w_armed_d = 1'b1;
                        end else begin
                            w_ferr_d = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                w_state_d = ST_IDLE;
                w_armed_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset discards any partial frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_tick_cnt_q <= '0;
            r_bit_cnt_q  <= '0;
            r_shift_q    <= '0;
            r_dout_q     <= '0;
            r_done_q     <= 1'b0;
            r_ferr_q     <= 1'b0;
            r_armed_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_tick_cnt_q <= w_tick_cnt_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_shift_q    <= w_shift_d;
            r_dout_q     <= w_dout_d;
            r_done_q     <= w_done_d;
            r_ferr_q     <= w_ferr_d;
            r_armed_q    <= w_armed_d;
        end
    end

    assign bus.dout         = r_dout_q;
    assign bus.rx_done_tick = r_done_q;
    assign bus.frame_err    = r_ferr_q;
    assign bus.state        = r_state_q;

endmodule : rx_uart
`default_nettype wire

// File: tb/tb_rx_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_uart
// Brief    : Self-checking bench for rx_uart: directed scenarios plus random
//            frames against a frame-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_uart;

    localparam int c_TICK_DIV = 10;
    localparam int c_BIT_CLKS = 16 * c_TICK_DIV;

    logic clk;
    logic rst;

    rx_uart_if #(.DW(8), .SW(4)) bus ();

    rx_uart dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick source: one clock high every c_TICK_DIV clocks
    int tick_div;
    initial begin
        tick_div   = 0;
        bus.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div   = (tick_div == c_TICK_DIV - 1) ? 0 : tick_div + 1;
            bus.s_tick = (tick_div == 0);
        end
    end

    // Pulse monitor
    int         done_cnt;
    int         ferr_cnt;
    int         both_cnt;
    logic [7:0] last_rx_byte;
    logic [7:0] got_q[$];
    initial begin
        done_cnt = 0; ferr_cnt = 0; both_cnt = 0; last_rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rx_done_tick) begin
                    done_cnt++;
                    last_rx_byte = bus.dout;
                    got_q.push_back(bus.dout);
                end
                if (bus.frame_err) ferr_cnt++;
                if (bus.rx_done_tick && bus.frame_err) both_cnt++;
            end
        end
    end

    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; holds the level for one bit period
    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (c_BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int clks);
        bus.rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    // Frame-level model state
    logic [7:0] exp_dout;
    int         exp_done;
    int         exp_ferr;

    initial begin
        tests_run = 0; tests_failed = 0;
        exp_dout = 8'h00; exp_done = 0; exp_ferr = 0;
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_state", 32'(bus.state), 32'h1);
        check("reset_dout", 32'(bus.dout), 32'h0);
        check("reset_done", 32'(bus.rx_done_tick), 32'h0);
        check("reset_ferr", 32'(bus.frame_err), 32'h0);
        rst = 1'b0;
        idle(200);

        // 1: clean frame
        send_frame(8'hA5, 1'b1);
        exp_dout = 8'hA5; exp_done++;
        idle(50);
        check("t1_done", 32'(done_cnt), 32'(exp_done));
        check("t1_dout", 32'(bus.dout), 32'(exp_dout));
        check("t1_mon_byte", 32'(last_rx_byte), 32'(exp_dout));
        check("t1_ferr", 32'(ferr_cnt), 32'(exp_ferr));

        // 2: short low glitch
        bus.rx = 1'b0;
        repeat (3 * c_TICK_DIV) @(negedge clk);
        check("t2_in_start", 32'(bus.state), 32'h2);
        idle(150);
        check("t2_back_idle", 32'(bus.state), 32'h1);
        check("t2_done", 32'(done_cnt), 32'(exp_done));
        check("t2_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        check("t2_dout", 32'(bus.dout), 32'(exp_dout));

        // 3: bad stop, line held low, then recover
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i));
        bus.rx = 1'b0;
        repeat (5 * c_BIT_CLKS) @(negedge clk);
        exp_ferr++;
        check("t3_ferr_once", 32'(ferr_cnt), 32'(exp_ferr));
        check("t3_no_done", 32'(done_cnt), 32'(exp_done));
        check("t3_dout_held", 32'(bus.dout), 32'(exp_dout));
        check("t3_idle_low", 32'(bus.state), 32'h1);
        idle(320);
        send_frame(8'h12, 1'b1);
        exp_dout = 8'h12; exp_done++;
        idle(50);
        check("t3_dout_12", 32'(bus.dout), 32'(exp_dout));
        check("t3_done", 32'(done_cnt), 32'(exp_done));

        // 4: back-to-back frames
        got_q.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        exp_dout = 8'hFF; exp_done += 2;
        idle(50);
        check("t4_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t4_first", 32'(got_q[0]), 32'h00);
            check("t4_second", 32'(got_q[1]), 32'hFF);
        end
        check("t4_dout", 32'(bus.dout), 32'(exp_dout));

        // 5: reset in the middle of data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        bus.rx = 1'b1;
        repeat (c_BIT_CLKS / 2) @(negedge clk);
        check("t5_in_data", 32'(bus.state), 32'h4);
        rst = 1'b1;
        #1;
        check("t5_rst_state", 32'(bus.state), 32'h1);
        check("t5_rst_dout", 32'(bus.dout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_dout = 8'h00;
        idle(320);
        check("t5_no_partial", 32'(done_cnt), 32'(exp_done));
        send_frame(8'h5A, 1'b1);
        exp_dout = 8'h5A; exp_done++;
        idle(50);
        check("t5_dout", 32'(bus.dout), 32'(exp_dout));

        // Random frames with random phase and occasional bad stop bits
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            idle($urandom_range(20, 220));
            send_frame(b, ok);
            if (ok) begin
                exp_dout = b;
                exp_done++;
            end else begin
                exp_ferr++;
            end
            idle(320);
            check("rnd_dout", 32'(bus.dout), 32'(exp_dout));
            check("rnd_done", 32'(done_cnt), 32'(exp_done));
            check("rnd_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        end

        check("never_both", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rx_uart
`default_nettype wire
